// File: rtl/clock_sequencer_pkg.sv
// Shared types and default widths for the clock run-control sequencer.
package clock_sequencer_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_BURST_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_HALT  = 3'd1,
    CMD_STEP  = 3'd2,
    CMD_BURST = 3'd3,
    CMD_RUN   = 3'd4
  } cmd_t;

endpackage

// File: rtl/clock_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module clock_sequencer_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up until all-ones, then hold; clear always wins
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_sequencer.sv
// Run-control for the clock generator enable: start, stop, single-step and
// N-cycle burst, plus a saturating count of enabled cycles.
// Optional RUN watchdog is built when CLOCK_SEQUENCER_WATCHDOG_EN is defined.
//
// state | meaning
// IDLE  | clock gated off, commands accepted (unless ext_halt)
// RUN   | clock enabled until halt / ext_halt / watchdog
// BURST | clock enabled for 'remaining' more cycles (step = burst of 1)
module clock_sequencer
  import clock_sequencer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BURST_W     = DEF_BURST_W,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               run,
  input  logic               halt,
  input  logic               step,
  input  logic               burst,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               ext_halt,
  input  logic               clear_count,
  output logic               clk_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               wdog_trip
);

  state_t             state, state_nxt;
  cmd_t               cmd;
  logic [BURST_W-1:0] remaining, remaining_nxt;
  logic               clk_en_nxt, done_nxt, wdog_trip_nxt;
  logic               run_start, wdog_hit;

  // idle command arbitration: halt > step > burst > run, all masked by ext_halt
  always_comb begin
    cmd = CMD_NONE;
    if (!ext_halt) begin
      if (halt)       cmd = CMD_HALT;
      else if (step)  cmd = CMD_STEP;
      else if (burst) cmd = CMD_BURST;
      else if (run)   cmd = CMD_RUN;
    end
  end

  // next-state and next-output logic; outputs are registered below
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    clk_en_nxt    = clk_en;
    done_nxt      = 1'b0;
    wdog_trip_nxt = wdog_trip;
    run_start     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd == CMD_STEP || cmd == CMD_BURST || cmd == CMD_RUN) wdog_trip_nxt = 1'b0;
        case (cmd)
          CMD_STEP: begin
            state_nxt     = BURST;
            remaining_nxt = BURST_W'(1);
            clk_en_nxt    = 1'b1;
          end
          CMD_BURST: begin
            if (burst_len == '0) begin
              // empty burst terminates at once; never pulse done back-to-back
              done_nxt = !done;
            end else begin
              state_nxt     = BURST;
              remaining_nxt = burst_len;
              clk_en_nxt    = 1'b1;
            end
          end
          CMD_RUN: begin
            state_nxt  = RUN;
            clk_en_nxt = 1'b1;
            run_start  = 1'b1;
          end
          default: ;
        endcase
      end
      RUN: begin
        if (halt || ext_halt || wdog_hit) begin
          state_nxt  = IDLE;
          clk_en_nxt = 1'b0;
          done_nxt   = 1'b1;
        end
      end
      BURST: begin
        remaining_nxt = remaining - 1'b1;
        if (halt || ext_halt || remaining == BURST_W'(1)) begin
          state_nxt     = IDLE;
          remaining_nxt = '0;
          clk_en_nxt    = 1'b0;
          done_nxt      = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        remaining_nxt = '0;
        clk_en_nxt    = 1'b0;
      end
    endcase
    if (wdog_hit) wdog_trip_nxt = 1'b1;
  end

  // state and output registers, so clk_en is glitch-free
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      remaining <= '0;
      clk_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wdog_trip <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      clk_en    <= clk_en_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      wdog_trip <= wdog_trip_nxt;
    end
  end

  clock_sequencer_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock  (clock),
    .nreset (nreset),
    .clear  (clear_count),
    .inc    (clk_en),
    .count  (cycle_count)
  );

`ifdef CLOCK_SEQUENCER_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] run_len;

  // run_len holds the number of RUN cycles already completed
  clock_sequencer_sat_counter #(.W(WDOG_W)) u_wdog_cnt (
    .clock  (clock),
    .nreset (nreset),
    .clear  (run_start),
    .inc    (state == RUN),
    .count  (run_len)
  );

  assign wdog_hit = (state == RUN) && (run_len == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clock_sequencer.sv
// Scoreboard bench for clock_sequencer: directed scenarios then random stimulus,
// checked against a cycle-level behavioural model. Honours CLOCK_SEQUENCER_WATCHDOG_EN.
module tb_clock_sequencer;

  localparam int  TB_WDOG = 10;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        run = 0, halt = 0, step = 0, burst = 0, ext_halt = 0, clear_count = 0;
  logic [15:0] burst_len = '0;

  logic        clk_en, busy, done, wdog_trip;
  logic [31:0] cycle_count;
  logic        clk_en4, busy4, done4, wdog_trip4;
  logic [3:0]  cycle_count4;

  int checks = 0;
  int failures = 0;

  clock_sequencer #(.CNT_W(32), .BURST_W(16), .WDOG_CYCLES(TB_WDOG)) dut (
    .clock(clock), .nreset(nreset), .run(run), .halt(halt), .step(step), .burst(burst),
    .burst_len(burst_len), .ext_halt(ext_halt), .clear_count(clear_count),
    .clk_en(clk_en), .busy(busy), .done(done), .cycle_count(cycle_count), .wdog_trip(wdog_trip)
  );

  clock_sequencer #(.CNT_W(4), .BURST_W(16), .WDOG_CYCLES(TB_WDOG)) dut4 (
    .clock(clock), .nreset(nreset), .run(run), .halt(halt), .step(step), .burst(burst),
    .burst_len(burst_len), .ext_halt(ext_halt), .clear_count(clear_count),
    .clk_en(clk_en4), .busy(busy4), .done(done4), .cycle_count(cycle_count4), .wdog_trip(wdog_trip4)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit     en, busy, done, wdog;
    longint cnt;
    int     cnt4;
  } exp_t;

  exp_t sb[$];

  // behavioural model: enabled cycles still owed by a burst, or free-running flag
  int     m_left;
  bit     m_running;
  bit     m_en, m_done, m_wdog;
  longint m_cnt;
  int     m_cnt4;
  int     m_runlen;

  task automatic model_reset();
    m_left = 0; m_running = 0; m_en = 0; m_done = 0; m_wdog = 0;
    m_cnt = 0; m_cnt4 = 0; m_runlen = 0;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // advance the model by one clock edge using the inputs being presented now
  task automatic model_step(bit r, bit h, bit s, bit b, int len, bit x, bit c);
    bit   hit, prev_done;
    int   l;
    exp_t e;
    if (c) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (m_en) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    hit = 0;
`ifdef CLOCK_SEQUENCER_WATCHDOG_EN
    if (m_running) begin
      m_runlen++;
      hit = (m_runlen == TB_WDOG);
    end
`endif
    prev_done = m_done;
    m_done = 0;
    if (m_running || m_left > 0) begin
      if (m_left > 0) m_left--;
      if (h || x || hit || (!m_running && m_left == 0)) begin
        m_running = 0; m_left = 0; m_en = 0; m_done = 1;
      end
      if (hit) m_wdog = 1;
    end else if (!x && !h && (s || b || r)) begin
      m_wdog = 0;
      if (s)      l = 1;
      else if (b) l = len;
      else        l = -1;
      if (l < 0) begin
        m_running = 1; m_runlen = 0; m_en = 1;
      end else if (l == 0) begin
        m_done = !prev_done;
      end else begin
        m_left = l; m_en = 1;
      end
    end
    e.en = m_en; e.busy = m_running || (m_left > 0); e.done = m_done; e.wdog = m_wdog;
    e.cnt = m_cnt; e.cnt4 = m_cnt4;
    sb.push_back(e);
  endtask

  // called 2 time units after a rising edge; returns at the same phase of the next edge
  task automatic drive(bit r, bit h, bit s, bit b, int len, bit x, bit c);
    run = r; halt = h; step = s; burst = b; burst_len = 16'(len); ext_halt = x; clear_count = c;
    model_step(r, h, s, b, len, x, c);
    @(posedge clock);
    #2;
  endtask

  task automatic idle(int n, bit x);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, x, 0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_clk_en"}, 64'(clk_en), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_count"}, 64'(cycle_count), 0);
    chk({tag, "_count4"}, 64'(cycle_count4), 0);
    chk({tag, "_wdog"}, 64'(wdog_trip), 0);
  endtask

  // monitor: compare each registered output set one time unit after the edge
  exp_t mon_e;
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("clk_en", 64'(clk_en), 64'(mon_e.en));
      chk("busy", 64'(busy), 64'(mon_e.busy));
      chk("done", 64'(done), 64'(mon_e.done));
      chk("cycle_count", 64'(cycle_count), mon_e.cnt);
      chk("cycle_count_w4", 64'(cycle_count4), 64'(mon_e.cnt4));
      chk("wdog_trip", 64'(wdog_trip), 64'(mon_e.wdog));
    end
  end

  initial begin
    bit r, h, s, b, x, c;
    int len;
    model_reset();
    #2 nreset = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (2) @(posedge clock);
    #2 nreset = 1'b1;

    // single step, then burst of 5, then empty burst
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(3, 0);
    drive(0, 0, 0, 1, 5, 0, 0);
    idle(7, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(2, 0);

    // run stopped by halt after 7 enabled cycles, then by ext_halt
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(6, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(2, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(6, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    idle(2, 1);
    idle(2, 0);

    // step+burst+run together, then clear coinciding with the enabled cycle
    drive(1, 0, 1, 1, 6, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(3, 0);

    // 20-cycle run: narrow counter saturates at 15
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(19, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(2, 0);

    // empty burst issued in a done cycle
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(1, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(2, 0);

    // long run (watchdog stops it when built), then a step clears the trip flag
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(13, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(1, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(3, 0);

    // asynchronous reset in the middle of a run
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(4, 0);
    #1 nreset = 1'b0;
    #1 check_all_zero("reset_mid_run");
    sb.delete();
    model_reset();
    @(posedge clock);
    #2 nreset = 1'b1;
    idle(4, 0);

    // random traffic
    x = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 9) == 0);
      h = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 11) == 0);
      b = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 40) == 0);
      len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      if ($urandom_range(0, 30) == 0) x = !x;
      drive(r, h, s, b, len, x, c);
    end
    idle(3, 0);

    if (sb.size() != 0) begin
      chk("scoreboard_drained", 64'(sb.size()), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
